// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - instruction RAM with serial byte-stream program loader and registered fetch port
// Optional checksum stage: define PROG_MEM_CHECKSUM_EN to require a trailing XOR byte.
module prog_mem_loader #(
    parameter int          DEPTH    = 256,
    parameter int          AW       = $clog2(DEPTH),
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic [31:0] last_pc,
    output logic        run,
    output logic        err
);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     n_lo_q, n_lo_d;
    logic [31:0]    last_pc_q, last_pc_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]  word_cnt_q, word_cnt_d;
    logic [23:0]    asm_q, asm_d;
    logic [31:0]    instr_q, instr_d;
`ifdef PROG_MEM_CHECKSUM_EN
    logic [7:0]     xor_q, xor_d;
`endif

    logic [31:0]    mem [DEPTH];
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata;

    logic           xfer;
    logic [15:0]    hdr_n;
    logic           fetch_ok;

    assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign run        = (state_q == S_RUN);
    assign err        = (state_q == S_ERR);
    assign last_pc    = last_pc_q;
    assign instr_data = instr_q;

    assign xfer     = byte_valid && byte_ready;
    assign hdr_n    = {byte_data, n_lo_q};
    // Full 32-bit compares so any nonzero upper address bit (e.g. the 0xFFFFFFFF wrap) fetches a NOP.
    assign fetch_ok = (instr_addr < 32'(DEPTH)) && (instr_addr <= last_pc_q);

    // Loader next-state: header capture, little-endian word assembly, RAM write strobe.
    always_comb begin
        state_d    = state_q;
        n_lo_d     = n_lo_q;
        last_pc_d  = last_pc_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        mem_we     = 1'b0;
        mem_waddr  = word_cnt_q;
        mem_wdata  = {byte_data, asm_q};
`ifdef PROG_MEM_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        if (xfer) begin
`ifdef PROG_MEM_CHECKSUM_EN
            xor_d = xor_q ^ byte_data;
`endif
            case (state_q)
                S_HDR0: begin
                    n_lo_d  = byte_data;
                    state_d = S_HDR1;
                end
                S_HDR1: begin
                    if ((hdr_n == 16'd0) || (32'(hdr_n) > 32'(DEPTH))) begin
                        state_d = S_ERR;
                    end else begin
                        last_pc_d = 32'(hdr_n) - 32'd1;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_cnt_q == 2'd3) begin
                        mem_we     = 1'b1;
                        byte_cnt_d = 2'd0;
                        word_cnt_d = word_cnt_q + AW'(1);
                        if (word_cnt_q == last_pc_q[AW-1:0]) begin
`ifdef PROG_MEM_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_RUN;
`endif
                        end
                    end else begin
                        // Shift in from the top so after three bytes asm_q = {b2, b1, b0}.
                        asm_d      = {byte_data, asm_q[23:8]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
`ifdef PROG_MEM_CHECKSUM_EN
                S_CSUM: begin
                    state_d = (byte_data == xor_q) ? S_RUN : S_ERR;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Fetch next-value: only a resident program is visible to the core.
    always_comb begin
        instr_d = NOP_WORD;
        if ((state_q == S_RUN) && fetch_ok) begin
            instr_d = mem[instr_addr[AW-1:0]];
        end
    end

    // Control and fetch registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HDR0;
            n_lo_q     <= 8'd0;
            last_pc_q  <= 32'd0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            asm_q      <= 24'd0;
            instr_q    <= NOP_WORD;
        end else begin
            state_q    <= state_d;
            n_lo_q     <= n_lo_d;
            last_pc_q  <= last_pc_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            instr_q    <= instr_d;
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    // Running XOR of every accepted byte ahead of the checksum byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q <= 8'd0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    // Instruction RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb/tb_prog_mem_loader.sv - directed self-checking bench for prog_mem_loader
module tb_prog_mem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] last_pc;
    logic        run;
    logic        err;

    int checks;
    int errors;

    prog_mem_loader #(.DEPTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .last_pc    (last_pc),
        .run        (run),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive at a falling edge; the byte transfers on the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'hEE;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        instr_addr = a;
        @(negedge clk);
        chk(tag, instr_data, exp);
    endtask

    logic [7:0] prog2 [10];

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        instr_addr = 32'd1;
        prog2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

        idle(2);
        chk("rst_ready",   {31'd0, byte_ready}, 32'd1);
        chk("rst_run",     {31'd0, run},        32'd0);
        chk("rst_err",     {31'd0, err},        32'd0);
        chk("rst_last_pc", last_pc,             32'd0);
        chk("rst_instr",   instr_data,          NOP);
        rst = 1'b0;
        idle(1);

        // Back-to-back two-word program, fetch address held at 1 throughout.
        for (int i = 0; i < 10; i++) send_byte(prog2[i]);
        chk("p2_run",      {31'd0, run},        32'd1);
        chk("p2_last_pc",  last_pc,             32'd1);
        chk("p2_ready",    {31'd0, byte_ready}, 32'd0);
        chk("p2_first_nop", instr_data,         NOP);
        @(negedge clk);
        chk("p2_first_run_fetch", instr_data, 32'h0020_0593);
        fetch("p2_addr0",   32'd0,         32'h0010_0513);
        fetch("p2_addr1",   32'd1,         32'h0020_0593);
        fetch("p2_addr2",   32'd2,         NOP);
        fetch("p2_addr_ff", 32'hFFFF_FFFF, NOP);
        fetch("p2_addr_hi", 32'h0000_0100, NOP);
        send_byte(8'h07);
        chk("p2_run_hold", {31'd0, run}, 32'd1);
        chk("p2_pc_hold",  last_pc,      32'd1);

        // Zero-length header.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("n0_err",   {31'd0, err},        32'd1);
        chk("n0_ready", {31'd0, byte_ready}, 32'd0);
        send_byte(8'h01);
        idle(2);
        chk("n0_run",   {31'd0, run},        32'd0);
        chk("n0_err_sticky", {31'd0, err},   32'd1);
        fetch("n0_fetch", 32'd0, NOP);

        // Header DEPTH+1.
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        chk("n257_err",   {31'd0, err},        32'd1);
        chk("n257_ready", {31'd0, byte_ready}, 32'd0);
        chk("n257_run",   {31'd0, run},        32'd0);

        // Same program with gaps; garbage on byte_data while idle must be ignored.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_byte(prog2[i]);
            idle((i % 3) + 1);
            if (i == 5) chk("gap_mid_run", {31'd0, run}, 32'd0);
        end
        chk("gap_run",     {31'd0, run}, 32'd1);
        chk("gap_last_pc", last_pc,      32'd1);
        fetch("gap_addr0", 32'd0, 32'h0010_0513);
        fetch("gap_addr1", 32'd1, 32'h0020_0593);

        // Reset after five data bytes, then a one-word program.
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(prog2[i]);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready",   {31'd0, byte_ready}, 32'd1);
        chk("mid_rst_last_pc", last_pc,             32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk("w1_run",     {31'd0, run}, 32'd1);
        chk("w1_last_pc", last_pc,      32'd0);
        fetch("w1_addr0", 32'd0, 32'hDDCC_BBAA);
        fetch("w1_addr1_stale", 32'd1, NOP);

`ifdef PROG_MEM_CHECKSUM_EN
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("cs_wait_run", {31'd0, run}, 32'd0);
        send_byte(8'h05);
        chk("cs_ok_run", {31'd0, run}, 32'd1);
        fetch("cs_addr0", 32'd0, 32'h0403_0201);
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h06);
        chk("cs_bad_err", {31'd0, err}, 32'd1);
        chk("cs_bad_run", {31'd0, run}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
